exec_alu_unit: RTL and testbench
================================

Name: exec_alu_unit

Overview:
- Execute-stage arithmetic block for the 5-stage MIPS-subset pipeline.
- Contains three parts:
  - ALU-control decode from ALUOp/funct.
  - 32-bit ALU.
  - Two 32-bit adders: PC+4 and branch target.
- All results are registered once on the rising edge, feeding the EX/MEM boundary.

Parameters:
- none (fixed 32-bit datapath, 3-bit ALU control, 2-bit ALUOp, 6-bit funct)

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  inputs valid this cycle; output registers load only when 1
- alu_op_i  in  2  ALUOp from main control
- funct_i  in  6  instruction funct field [5:0]
- data1_i  in  32  ALU operand A (forwarded rs value)
- data2_i  in  32  ALU operand B (forwarded rt value or sign-extended immediate)
- pc_i  in  32  address of the instruction
- imm_i  in  32  sign-extended immediate, used for the branch target
- alu_ctrl_o  out  3  registered ALU control code
- result_o  out  32  registered ALU result
- zero_o  out  1  registered flag, 1 when ALU result == 0
- pc_plus4_o  out  32  registered pc_i + 4
- branch_target_o  out  32  registered pc_i + 4 + (imm_i << 2)
- valid_o  out  1  registered valid_i

Behaviour:
- Clock and reset: one clock. rst_i is synchronous and active-high, sampled on the rising edge of clk_i.
- Reset: on a rising edge with rst_i=1, all outputs go to 0, regardless of valid_i.
- Latency: exactly 1 cycle. Inputs sampled at edge N with valid_i=1 appear on the outputs after edge N.
- valid_i=0 (no reset):
  - result_o, zero_o, alu_ctrl_o, pc_plus4_o and branch_target_o hold their previous values.
  - valid_o <= 0.
- ALU-control decode (combinational, then registered):
  - alu_op 00 -> 010 (add: lw/sw/addi)
  - alu_op 01 -> 110 (sub: beq)
  - alu_op 11 -> 001 (or: ori)
  - alu_op 10 -> decode funct_i:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
    - 011000 -> 011 (mul)
    - any other funct -> 010 (add)
- ALU operations by code:
  - 000 A & B
  - 001 A | B
  - 010 A + B, modulo 2^32; overflow ignored, no trap
  - 110 A - B, modulo 2^32
  - 111 signed compare: 32'd1 if $signed(A) < $signed(B), else 0
  - 011 low 32 bits of the signed product A*B
  - unused codes 100, 101 -> result 0
- zero_o: 1 iff the selected ALU result is all zeros, computed from the same result that is loaded into result_o.
- Adders:
  - pc_plus4 = pc_i + 32'd4.
  - branch_target = pc_plus4 + {imm_i[29:0], 2'b00}.
  - Both adders wrap modulo 2^32; no carry out.
- Simultaneous rst_i and valid_i: reset wins.
- Reset mid-stream: the reset cycle's inputs are discarded. The next valid cycle proceeds normally with no residual state.

Test Plan:
- Reset then R-type add. rst_i=1 for 2 cycles -> all outputs 0. Then alu_op=10, funct=100000, A=5, B=7, pc=0x100, imm=0, valid=1 -> next cycle: result_o=12, zero_o=0, alu_ctrl_o=010, pc_plus4_o=0x104, branch_target_o=0x104, valid_o=1.
- beq path. alu_op=01, A=B=0x1234, pc=0x40, imm=0xFFFFFFFE -> result_o=0, zero_o=1, alu_ctrl_o=110, branch_target_o=0x3C.
- Logic ops and slt:
  - and: A=0xF0F0F0F0, B=0x0FF00FF0 -> 0x00F000F0.
  - or: same A and B -> 0xFFF0FFF0.
  - slt: A=0xFFFFFFFF (-1), B=1 -> 1; swapped operands -> 0 with zero_o=1.
- mul and wrap:
  - mul: A=0x00010000, B=0x00010000 -> result_o=0, zero_o=1.
  - mul: A=-3, B=7 -> 0xFFFFFFEB.
  - add wrap: A=0xFFFFFFFF, B=2 -> 1.
  - PC wrap: pc=0xFFFFFFFC -> pc_plus4_o=0.
- Hold and default decode:
  - valid_i=0 for 3 cycles with changing inputs -> data outputs unchanged, valid_o=0.
  - alu_op=10, funct=000111 -> alu_ctrl_o=010 (add).
  - alu_op=11, A=0x0F, B=0xF0 -> result_o=0xFF.
- Reset priority: rst_i=1 together with valid_i=1 and A=B=1 (add) -> all outputs 0 after the edge. The next valid add (3+4) gives 7.

Source files
------------

// File: rtl/exec_alu_unit.sv
// ----------------------------------------------------------------------------
// exec_alu_unit
//   Execute-stage arithmetic block of the 5-stage MIPS-subset pipeline.
//   Decodes the ALU control code from ALUOp/funct, runs the 32-bit ALU and
//   computes PC+4 and the branch target. Every result is registered once,
//   feeding the EX/MEM boundary.
//
// Ports
//   clk_i            in   1  system clock, rising edge
//   rst_i            in   1  synchronous active-high reset (all outputs -> 0)
//   valid_i          in   1  inputs valid; data registers load only when 1
//   alu_op_i         in   2  ALUOp from main control
//   funct_i          in   6  instruction funct field
//   data1_i          in  32  ALU operand A
//   data2_i          in  32  ALU operand B
//   pc_i             in  32  address of the instruction
//   imm_i            in  32  sign-extended immediate for the branch target
//   alu_ctrl_o       out  3  registered ALU control code
//   result_o         out 32  registered ALU result
//   zero_o           out  1  registered (result == 0)
//   pc_plus4_o       out 32  registered pc_i + 4
//   branch_target_o  out 32  registered pc_i + 4 + (imm_i << 2)
//   valid_o          out  1  registered valid_i
// ----------------------------------------------------------------------------
module exec_alu_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [1:0]  alu_op_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  output logic [2:0]  alu_ctrl_o,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] branch_target_o,
  output logic        valid_o
);

  typedef enum logic [2:0] {
    CTRL_AND  = 3'b000,
    CTRL_OR   = 3'b001,
    CTRL_ADD  = 3'b010,
    CTRL_MUL  = 3'b011,
    CTRL_RSV4 = 3'b100,
    CTRL_RSV5 = 3'b101,
    CTRL_SUB  = 3'b110,
    CTRL_SLT  = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  // --------------------------------------------------------------------------
  // ALU-control decode
  // --------------------------------------------------------------------------
  alu_ctrl_e alu_ctrl;

  always_comb begin
    alu_ctrl = CTRL_ADD;
    unique case (alu_op_e'(alu_op_i))
      ALUOP_ADD: alu_ctrl = CTRL_ADD;
      ALUOP_SUB: alu_ctrl = CTRL_SUB;
      ALUOP_OR:  alu_ctrl = CTRL_OR;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: alu_ctrl = CTRL_ADD;
          FUNCT_SUB: alu_ctrl = CTRL_SUB;
          FUNCT_AND: alu_ctrl = CTRL_AND;
          FUNCT_OR:  alu_ctrl = CTRL_OR;
          FUNCT_SLT: alu_ctrl = CTRL_SLT;
          FUNCT_MUL: alu_ctrl = CTRL_MUL;
          // Unknown funct falls back to add rather than trapping.
          default:   alu_ctrl = CTRL_ADD;
        endcase
      end
      default: alu_ctrl = CTRL_ADD;
    endcase
  end

  // --------------------------------------------------------------------------
  // 32-bit ALU
  // --------------------------------------------------------------------------
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] prod_lo;
  logic        lt_signed;
  logic [31:0] alu_result;

  assign sum  = data1_i + data2_i;
  assign diff = data1_i - data2_i;
  // Low half of a two's-complement product does not depend on signedness.
  assign prod_lo   = data1_i * data2_i;
  assign lt_signed = ($signed(data1_i) < $signed(data2_i));

  always_comb begin
    alu_result = '0;
    unique case (alu_ctrl)
      CTRL_AND:  alu_result = data1_i & data2_i;
      CTRL_OR:   alu_result = data1_i | data2_i;
      CTRL_ADD:  alu_result = sum;
      CTRL_SUB:  alu_result = diff;
      CTRL_SLT:  alu_result = {31'd0, lt_signed};
      CTRL_MUL:  alu_result = prod_lo;
      CTRL_RSV4: alu_result = '0;
      CTRL_RSV5: alu_result = '0;
      default:   alu_result = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // PC adders
  // --------------------------------------------------------------------------
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  assign pc_plus4      = pc_i + 32'd4;
  assign branch_target = pc_plus4 + {imm_i[29:0], 2'b00};

  // --------------------------------------------------------------------------
  // EX/MEM registers
  // --------------------------------------------------------------------------
  logic [2:0]  alu_ctrl_q,      alu_ctrl_d;
  logic [31:0] result_q,        result_d;
  logic        zero_q,          zero_d;
  logic [31:0] pc_plus4_q,      pc_plus4_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic        valid_q,         valid_d;

  always_comb begin
    alu_ctrl_d      = alu_ctrl_q;
    result_d        = result_q;
    zero_d          = zero_q;
    pc_plus4_d      = pc_plus4_q;
    branch_target_d = branch_target_q;
    valid_d         = valid_i;
    if (valid_i) begin
      alu_ctrl_d      = alu_ctrl;
      result_d        = alu_result;
      zero_d          = (alu_result == '0);
      pc_plus4_d      = pc_plus4;
      branch_target_d = branch_target;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_ctrl_q      <= '0;
      result_q        <= '0;
      zero_q          <= 1'b0;
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
      valid_q         <= 1'b0;
    end else begin
      alu_ctrl_q      <= alu_ctrl_d;
      result_q        <= result_d;
      zero_q          <= zero_d;
      pc_plus4_q      <= pc_plus4_d;
      branch_target_q <= branch_target_d;
      valid_q         <= valid_d;
    end
  end

  assign alu_ctrl_o      = alu_ctrl_q;
  assign result_o        = result_q;
  assign zero_o          = zero_q;
  assign pc_plus4_o      = pc_plus4_q;
  assign branch_target_o = branch_target_q;
  assign valid_o         = valid_q;

endmodule

// File: tb/tb_exec_alu_unit.sv
// ----------------------------------------------------------------------------
// tb_exec_alu_unit
//   Directed steps followed by random traffic for exec_alu_unit, each cycle
//   compared against a behavioural model of the EX/MEM registers.
// ----------------------------------------------------------------------------
module tb_exec_alu_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  alu_op_i = '0;
  logic [5:0]  funct_i = '0;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [31:0] pc_i = '0;
  logic [31:0] imm_i = '0;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] branch_target_o;
  logic        valid_o;

  exec_alu_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (valid_i),
    .alu_op_i        (alu_op_i),
    .funct_i         (funct_i),
    .data1_i         (data1_i),
    .data2_i         (data2_i),
    .pc_i            (pc_i),
    .imm_i           (imm_i),
    .alu_ctrl_o      (alu_ctrl_o),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .pc_plus4_o      (pc_plus4_o),
    .branch_target_o (branch_target_o),
    .valid_o         (valid_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Expected register contents
  logic [2:0]  m_ctrl   = '0;
  logic [31:0] m_res    = '0;
  logic        m_zero   = 1'b0;
  logic [31:0] m_pc4    = '0;
  logic [31:0] m_bt     = '0;
  logic        m_valid  = 1'b0;

  function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 3'd2;
    if (op == 2'd1) return 3'd6;
    if (op == 2'd3) return 3'd1;
    if (f == 6'd32) return 3'd2;
    if (f == 6'd34) return 3'd6;
    if (f == 6'd36) return 3'd0;
    if (f == 6'd37) return 3'd1;
    if (f == 6'd42) return 3'd7;
    if (f == 6'd24) return 3'd3;
    return 3'd2;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd6: return 32'((longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000);
      3'd7: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: begin p = sa * sb; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    if (rst_i) begin
      m_ctrl = '0; m_res = '0; m_zero = 1'b0; m_pc4 = '0; m_bt = '0; m_valid = 1'b0;
    end else begin
      m_valid = valid_i;
      if (valid_i) begin
        m_ctrl = ref_ctrl(alu_op_i, funct_i);
        m_res  = ref_alu(m_ctrl, data1_i, data2_i);
        m_zero = (m_res == 32'd0);
        m_pc4  = 32'((longint'(pc_i) + 4) % 64'h1_0000_0000);
        m_bt   = 32'((longint'(m_pc4) + longint'(imm_i) * 4) % 64'h1_0000_0000);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ctrl"},  {29'd0, alu_ctrl_o}, {29'd0, m_ctrl});
    check({tag, ".res"},   result_o, m_res);
    check({tag, ".zero"},  {31'd0, zero_o}, {31'd0, m_zero});
    check({tag, ".pc4"},   pc_plus4_o, m_pc4);
    check({tag, ".bt"},    branch_target_o, m_bt);
    check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, m_valid});
  endtask

  task automatic step(input string tag, input logic rst, input logic v, input logic [1:0] op,
                      input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] imm);
    @(negedge clk_i);
    rst_i = rst; valid_i = v; alu_op_i = op; funct_i = f;
    data1_i = a; data2_i = b; pc_i = pc; imm_i = imm;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [5:0] flist [7];
    logic [31:0] hold_res;
    flist = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000, 6'b000111};

    // Reset, then R-type add
    step("rst0", 1, 1, 2'b10, 6'b100000, 32'd9, 32'd9, 32'h10, 32'd1);
    step("rst1", 1, 0, 2'b00, 6'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("rst.res_zero", result_o, 32'd0);
    step("add", 0, 1, 2'b10, 6'b100000, 32'd5, 32'd7, 32'h100, 32'd0);
    check("tp.add.res", result_o, 32'd12);
    check("tp.add.ctrl", {29'd0, alu_ctrl_o}, 32'd2);
    check("tp.add.bt", branch_target_o, 32'h104);

    // beq
    step("beq", 0, 1, 2'b01, 6'b0, 32'h1234, 32'h1234, 32'h40, 32'hFFFF_FFFE);
    check("tp.beq.bt", branch_target_o, 32'h3C);
    check("tp.beq.zero", {31'd0, zero_o}, 32'd1);

    // Logic ops and slt
    step("and", 0, 1, 2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'd3);
    check("tp.and", result_o, 32'h00F0_00F0);
    step("or",  0, 1, 2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h8, 32'd3);
    check("tp.or", result_o, 32'hFFF0_FFF0);
    step("slt1", 0, 1, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'd0);
    check("tp.slt1", result_o, 32'd1);
    step("slt0", 0, 1, 2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'h8, 32'd0);
    check("tp.slt0.zero", {31'd0, zero_o}, 32'd1);

    // mul and wrap
    step("mul0", 0, 1, 2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0000, 32'h20, 32'd0);
    check("tp.mul0.zero", {31'd0, zero_o}, 32'd1);
    step("mulneg", 0, 1, 2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7, 32'h20, 32'd0);
    check("tp.mulneg", result_o, 32'hFFFF_FFEB);
    step("addwrap", 0, 1, 2'b00, 6'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFC, 32'd0);
    check("tp.addwrap", result_o, 32'd1);
    check("tp.pcwrap", pc_plus4_o, 32'd0);

    // Hold with valid low
    hold_res = result_o;
    for (int i = 0; i < 3; i++)
      step("hold", 0, 0, 2'($urandom), 6'($urandom), $urandom, $urandom, $urandom, $urandom);
    check("tp.hold.res", result_o, hold_res);

    // Default decode and ori
    step("deffunct", 0, 1, 2'b10, 6'b000111, 32'd10, 32'd20, 32'h50, 32'd0);
    check("tp.def.ctrl", {29'd0, alu_ctrl_o}, 32'd2);
    step("ori", 0, 1, 2'b11, 6'b0, 32'h0F, 32'hF0, 32'h50, 32'd0);
    check("tp.ori", result_o, 32'hFF);

    // Reset priority over valid
    step("rstprio", 1, 1, 2'b00, 6'b0, 32'd1, 32'd1, 32'h60, 32'd4);
    check("tp.rstprio.res", result_o, 32'd0);
    step("post_rst", 0, 1, 2'b00, 6'b0, 32'd3, 32'd4, 32'h60, 32'd4);
    check("tp.post_rst", result_o, 32'd7);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      logic r, v;
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($signed(16'($urandom)));
      step("rand", r, v, 2'($urandom), flist[$urandom_range(0, 6)], a, b, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
